// File: rtl/aes_prng_clearing_gen2_pkg.sv
// Shared types, tap constants, default seed/permutations and reseed FSM encoding
// for the clearing PRNG and its entropy packer.
package aes_prng_clearing_gen2_pkg;

  localparam int unsigned EdnBusWidth      = 32;
  localparam int unsigned ClearingMaxWidth = 128;
  localparam int unsigned PermIdxW         = 8;

  typedef logic [ClearingMaxWidth-1:0]               clearing_lfsr_seed_t;
  typedef logic [ClearingMaxWidth-1:0][PermIdxW-1:0] clearing_perm_t;

  // Galois feedback masks for a right-shifting LFSR, zero-extended to the widest variant.
  localparam clearing_lfsr_seed_t ClearingTaps64  = 128'h0000_0000_0000_0000_D800_0000_0000_0000;
  localparam clearing_lfsr_seed_t ClearingTaps128 = 128'hA000_0014_0000_0000_0000_0000_0000_0000;

  localparam clearing_lfsr_seed_t RndCnstClearingLfsrSeedDefault =
    128'h3C8E_71A5_0F2B_D946_8B17_E4C0_5A93_26DF;

  // Affine index maps i -> (i*mul + add) mod width; an odd multiplier keeps them bijective.
  localparam int unsigned LfsrPermMul  = 37;
  localparam int unsigned LfsrPermAdd  = 11;
  localparam int unsigned SharePermMul = 21;
  localparam int unsigned SharePermAdd = 5;

  typedef enum logic [4:0] {
    IDLE    = 5'b01110,
    COLLECT = 5'b10011
  } prng_reseed_state_e;

  function automatic clearing_lfsr_seed_t clearing_taps(input int unsigned width);
    return (width == 128) ? ClearingTaps128 : ClearingTaps64;
  endfunction

  function automatic clearing_perm_t gen_perm(input int unsigned width,
                                              input int unsigned mul,
                                              input int unsigned add);
    clearing_perm_t perm;
    perm = '0;
    for (int unsigned i = 0; i < ClearingMaxWidth; i++) begin
      if (i < width) begin
        perm[i] = PermIdxW'((i * mul + add) % width);
      end
    end
    return perm;
  endfunction

endpackage

// File: rtl/aes_prng_clearing_gen2_entropy_packer.sv
// Packs Width/EntropyWidth EDN beats into one seed, first beat in the MSBs.
// seed_o/seed_vld_o are combinational with the final beat; no backpressure, every beat is taken.
module aes_prng_clearing_gen2_entropy_packer
  import aes_prng_clearing_gen2_pkg::*;
#(
  parameter int unsigned Width        = 64,
  parameter int unsigned EntropyWidth = EdnBusWidth
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    beat_vld_i,
  input  logic [EntropyWidth-1:0] beat_dat_i,
  output logic [Width-1:0]        seed_o,
  output logic                    seed_vld_o
);

  localparam int unsigned NumBeats = Width / EntropyWidth;
  localparam int unsigned BeatCntW = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam logic [BeatCntW-1:0] LastBeat = BeatCntW'(NumBeats - 1);

  logic [BeatCntW-1:0] beat_cnt_q;
  logic [Width-1:0]    buf_q;

  assign seed_o     = (buf_q << EntropyWidth) | Width'(beat_dat_i);
  assign seed_vld_o = beat_vld_i & (beat_cnt_q == LastBeat);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      beat_cnt_q <= '0;
      buf_q      <= '0;
    end else if (beat_vld_i) begin
      if (seed_vld_o) begin
        beat_cnt_q <= '0;
        buf_q      <= '0;
      end else begin
        beat_cnt_q <= beat_cnt_q + 1'b1;
        buf_q      <= seed_o;
      end
    end
  end

endmodule

// File: rtl/aes_prng_clearing_gen2.sv
// Clearing PRNG: Galois LFSR feeding NumShares permuted shares, reseeded from EDN on request or periodically.
// Latency: data_ack_o is combinational, LFSR advances at the acking edge; data acks stall while a reseed is pending.
module aes_prng_clearing_gen2
  import aes_prng_clearing_gen2_pkg::*;
#(
  parameter int unsigned    Width                = 64,
  parameter int unsigned    EntropyWidth         = EdnBusWidth,
  parameter int unsigned    NumShares            = 2,
  parameter int unsigned    ReseedInterval       = 0,
  parameter bit             SecSkipPRNGReseeding = 1'b0,
  parameter logic [Width-1:0] RndCnstLfsrSeed    = RndCnstClearingLfsrSeedDefault[Width-1:0],
  parameter clearing_perm_t RndCnstLfsrPerm      = gen_perm(Width, LfsrPermMul, LfsrPermAdd),
  parameter clearing_perm_t RndCnstSharePerm     = gen_perm(Width, SharePermMul, SharePermAdd)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    data_req_i,
  output logic                    data_ack_o,
  output logic [Width-1:0]        data_o [NumShares],
  input  logic                    reseed_req_i,
  output logic                    reseed_ack_o,
  output logic                    reseed_busy_o,
  output logic                    lockup_o,
  output logic                    entropy_req_o,
  input  logic                    entropy_ack_i,
  input  logic [EntropyWidth-1:0] entropy_i
);

  if (!(Width == 64 || Width == 128)) begin : g_bad_width
    $error("aes_prng_clearing_gen2: Width must be 64 or 128");
  end
  if (EntropyWidth == 0 || EntropyWidth > Width || (Width % EntropyWidth) != 0) begin : g_bad_ew
    $error("aes_prng_clearing_gen2: EntropyWidth must divide Width");
  end
  if (NumShares < 1 || NumShares > 4) begin : g_bad_shares
    $error("aes_prng_clearing_gen2: NumShares must be 1..4");
  end
  if (RndCnstLfsrSeed == '0) begin : g_bad_seed
    $error("aes_prng_clearing_gen2: RndCnstLfsrSeed must be non-zero");
  end

  localparam int unsigned IdxW = $clog2(Width);
  localparam clearing_lfsr_seed_t TapsFull = clearing_taps(Width);
  localparam logic [Width-1:0] Taps = TapsFull[Width-1:0];

  localparam int unsigned AckCntW = (ReseedInterval > 0) ? $clog2(ReseedInterval + 1) : 1;
  localparam logic [AckCntW-1:0] AckCntMax = AckCntW'(ReseedInterval);

  prng_reseed_state_e state_q;
  logic [Width-1:0]   lfsr_q;
  logic [Width-1:0]   lfsr_next;
  logic [AckCntW-1:0] ack_cnt_q;
  logic               entropy_req_q;
  logic               busy_q;
  logic               lockup_q;

  logic               is_idle;
  logic               is_collect;
  logic               auto_due;
  logic               beat_vld;
  logic               seed_vld;
  logic [Width-1:0]   seed;

  assign is_idle    = (state_q == IDLE);
  assign is_collect = (state_q == COLLECT);
  assign auto_due   = (ReseedInterval != 0) && !SecSkipPRNGReseeding && (ack_cnt_q == AckCntMax);
  assign beat_vld   = is_collect & entropy_ack_i;

  assign data_ack_o    = data_req_i & is_idle & ~reseed_req_i & ~auto_due;
  assign reseed_ack_o  = SecSkipPRNGReseeding ? reseed_req_i : (seed_vld & reseed_req_i);
  assign entropy_req_o = entropy_req_q;
  assign reseed_busy_o = busy_q;
  assign lockup_o      = lockup_q;

  assign lfsr_next = (lfsr_q >> 1) ^ ({Width{lfsr_q[0]}} & Taps);

  // A corrupted state encoding also flushes any partially packed seed.
  aes_prng_clearing_gen2_entropy_packer #(
    .Width        (Width),
    .EntropyWidth (EntropyWidth)
  ) u_packer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (~is_idle & ~is_collect),
    .beat_vld_i (beat_vld),
    .beat_dat_i (entropy_i),
    .seed_o     (seed),
    .seed_vld_o (seed_vld)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      lfsr_q        <= RndCnstLfsrSeed;
      ack_cnt_q     <= '0;
      entropy_req_q <= 1'b0;
      busy_q        <= 1'b0;
      lockup_q      <= 1'b0;
    end else begin
      if (lfsr_q == '0) begin
        lockup_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if ((reseed_req_i || auto_due) && !SecSkipPRNGReseeding) begin
            state_q       <= COLLECT;
            entropy_req_q <= 1'b1;
            busy_q        <= 1'b1;
          end else if (data_ack_o) begin
            lfsr_q <= lfsr_next;
            if (ack_cnt_q != AckCntMax) begin
              ack_cnt_q <= ack_cnt_q + 1'b1;
            end
          end
        end
        COLLECT: begin
          if (seed_vld) begin
            // An all-zero seed would freeze the LFSR, so fall back to the constant.
            lfsr_q        <= (seed == '0) ? RndCnstLfsrSeed : seed;
            ack_cnt_q     <= '0;
            state_q       <= IDLE;
            entropy_req_q <= 1'b0;
            busy_q        <= 1'b0;
          end
        end
        default: begin
          state_q       <= IDLE;
          entropy_req_q <= 1'b0;
          busy_q        <= 1'b0;
          lockup_q      <= 1'b1;
        end
      endcase
    end
  end

  // Share 0 permutes the state; every further share permutes its predecessor.
  always_comb begin
    logic [Width-1:0] cur;
    logic [Width-1:0] nxt;
    cur = '0;
    nxt = '0;
    for (int i = 0; i < Width; i++) begin
      cur[i] = lfsr_q[RndCnstLfsrPerm[i][IdxW-1:0]];
    end
    for (int s = 0; s < NumShares; s++) begin
      data_o[s] = cur;
      for (int i = 0; i < Width; i++) begin
        nxt[i] = cur[RndCnstSharePerm[i][IdxW-1:0]];
      end
      cur = nxt;
    end
  end

endmodule

// File: tb/tb_aes_prng_clearing_gen2.sv
// Bench for the clearing PRNG: directed reseed scenarios plus a random phase against a queue-based model.
module tb_aes_prng_clearing_gen2;
  import aes_prng_clearing_gen2_pkg::*;

  localparam logic [63:0] TbSeed = 64'h5A5A_1234_C3C3_9876;
  localparam logic [63:0] TbTaps = 64'hD800_0000_0000_0000;
  localparam int          TbInterval = 4;

  function automatic clearing_perm_t mk_rev_perm();
    clearing_perm_t p;
    p = '0;
    for (int i = 0; i < 64; i++) p[i] = 8'(63 - i);
    return p;
  endfunction

  function automatic clearing_perm_t mk_rot_perm();
    clearing_perm_t p;
    p = '0;
    for (int i = 0; i < 64; i++) p[i] = 8'((i + 7) % 64);
    return p;
  endfunction

  localparam clearing_perm_t TbLfsrPerm  = mk_rev_perm();
  localparam clearing_perm_t TbSharePerm = mk_rot_perm();

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_req = 1'b0, reseed_req = 1'b0, entropy_ack = 1'b0;
  logic [31:0] entropy = '0;
  logic        data_ack, reseed_ack, reseed_busy, lockup, entropy_req;
  logic [63:0] data_o [2];

  logic        s_data_req = 1'b0, s_reseed_req = 1'b0, s_entropy_ack = 1'b0;
  logic [31:0] s_entropy = '0;
  logic        s_data_ack, s_reseed_ack, s_reseed_busy, s_lockup, s_entropy_req;
  logic [63:0] s_data_o [2];

  int n_cmp = 0;
  int n_fail = 0;

  logic [63:0] m_lfsr;
  bit          m_coll;
  int          m_acks;
  logic [31:0] m_beats [$];
  logic [63:0] sk_lfsr;

  always #5 clk = ~clk;

  aes_prng_clearing_gen2 #(
    .Width(64), .EntropyWidth(32), .NumShares(2), .ReseedInterval(TbInterval),
    .SecSkipPRNGReseeding(1'b0), .RndCnstLfsrSeed(TbSeed),
    .RndCnstLfsrPerm(TbLfsrPerm), .RndCnstSharePerm(TbSharePerm)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .data_req_i(data_req), .data_ack_o(data_ack), .data_o(data_o),
    .reseed_req_i(reseed_req), .reseed_ack_o(reseed_ack), .reseed_busy_o(reseed_busy),
    .lockup_o(lockup), .entropy_req_o(entropy_req), .entropy_ack_i(entropy_ack), .entropy_i(entropy)
  );

  aes_prng_clearing_gen2 #(
    .Width(64), .EntropyWidth(32), .NumShares(2), .ReseedInterval(TbInterval),
    .SecSkipPRNGReseeding(1'b1), .RndCnstLfsrSeed(TbSeed),
    .RndCnstLfsrPerm(TbLfsrPerm), .RndCnstSharePerm(TbSharePerm)
  ) u_skip (
    .clk_i(clk), .rst_i(rst), .data_req_i(s_data_req), .data_ack_o(s_data_ack), .data_o(s_data_o),
    .reseed_req_i(s_reseed_req), .reseed_ack_o(s_reseed_ack), .reseed_busy_o(s_reseed_busy),
    .lockup_o(s_lockup), .entropy_req_o(s_entropy_req), .entropy_ack_i(s_entropy_ack), .entropy_i(s_entropy)
  );

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return s[0] ? ((s >> 1) ^ TbTaps) : (s >> 1);
  endfunction

  // Share 0 is the bit-reversed state, share 1 is share 0 rotated right by 7.
  function automatic logic [63:0] share0(input logic [63:0] s);
    return {<<{s}};
  endfunction

  function automatic logic [63:0] share1(input logic [63:0] s);
    logic [63:0] x;
    x = share0(s);
    return (x >> 7) | (x << 57);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lfsr = TbSeed;
    m_coll = 1'b0;
    m_acks = 0;
    m_beats.delete();
  endtask

  // One clock of the main instance: drive at edge+1, check at negedge, advance the model at the edge.
  task automatic cycle(input bit dreq, input bit rreq, input bit eack, input logic [31:0] edat);
    bit          exp_dack;
    bit          exp_rack;
    logic [63:0] newseed;
    data_req    = dreq;
    reseed_req  = rreq;
    entropy_ack = eack;
    entropy     = edat;
    exp_dack = dreq && !m_coll && !rreq && (m_acks != TbInterval);
    exp_rack = m_coll && eack && (m_beats.size() == 1) && rreq;
    @(negedge clk);
    chk("data_ack", 64'(data_ack), 64'(exp_dack));
    chk("reseed_ack", 64'(reseed_ack), 64'(exp_rack));
    chk("entropy_req", 64'(entropy_req), 64'(m_coll));
    chk("reseed_busy", 64'(reseed_busy), 64'(m_coll));
    chk("lockup", 64'(lockup), 64'd0);
    chk("share0", data_o[0], share0(m_lfsr));
    chk("share1", data_o[1], share1(m_lfsr));
    @(posedge clk);
    if (!m_coll) begin
      if (rreq || m_acks == TbInterval) begin
        m_coll = 1'b1;
      end else if (exp_dack) begin
        m_lfsr = lfsr_step(m_lfsr);
        if (m_acks < TbInterval) m_acks++;
      end
    end else if (eack) begin
      if (m_beats.size() == 1) begin
        newseed = {m_beats[0], edat};
        m_lfsr  = (newseed == 64'd0) ? TbSeed : newseed;
        m_beats.delete();
        m_acks  = 0;
        m_coll  = 1'b0;
      end else begin
        m_beats.push_back(edat);
      end
    end
    #1;
  endtask

  initial begin
    model_reset();
    sk_lfsr = TbSeed;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state of the bypass instance (main instance is checked by the first cycle()).
    @(negedge clk);
    chk("skip_rst_entropy_req", 64'(s_entropy_req), 64'd0);
    chk("skip_rst_busy", 64'(s_reseed_busy), 64'd0);
    chk("skip_rst_lockup", 64'(s_lockup), 64'd0);
    chk("skip_rst_share0", s_data_o[0], share0(TbSeed));
    @(posedge clk);
    #1;

    // Reset outputs, then three consecutive data requests.
    cycle(0, 0, 0, 32'h0);
    repeat (3) cycle(1, 0, 0, $urandom);

    // External reseed with two beats; data requests held to confirm they stall.
    cycle(1, 1, 0, 32'h0);
    cycle(1, 1, 1, 32'hDEADBEEF);
    cycle(1, 1, 1, 32'h01234567);
    cycle(0, 0, 0, 32'h0);
    chk("reseed_value", data_o[0], share0(64'hDEADBEEF_01234567));

    // All-zero entropy falls back to the constant seed.
    cycle(0, 1, 0, 32'h0);
    cycle(0, 1, 1, 32'h0);
    cycle(0, 1, 1, 32'h0);
    cycle(0, 0, 0, 32'h0);
    chk("zero_seed_fallback", data_o[0], share0(TbSeed));

    // Periodic reseed after four acks, with a stalled beat in the middle.
    repeat (4) cycle(1, 0, 0, 32'h0);
    cycle(1, 0, 0, 32'h0);
    cycle(1, 0, 1, $urandom);
    cycle(1, 0, 0, 32'h0);
    cycle(1, 0, 1, $urandom);
    repeat (2) cycle(1, 0, 0, 32'h0);

    // Reset in the middle of a collection discards the partial seed.
    cycle(0, 1, 0, 32'h0);
    cycle(0, 1, 1, $urandom);
    rst = 1'b1; reseed_req = 1'b0; entropy_ack = 1'b0; data_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    cycle(0, 0, 0, 32'h0);
    cycle(0, 1, 0, 32'h0);
    cycle(0, 1, 1, $urandom);
    cycle(0, 1, 0, 32'h0);
    cycle(0, 1, 1, $urandom);
    cycle(0, 0, 0, 32'h0);

    // External request rising during a periodic collection merges into it.
    repeat (4) cycle(1, 0, 0, 32'h0);
    cycle(0, 0, 0, 32'h0);
    cycle(0, 1, 1, $urandom);
    cycle(0, 1, 1, $urandom);
    cycle(0, 0, 0, 32'h0);

    // Request dropped mid-collection: completes silently.
    cycle(0, 1, 0, 32'h0);
    cycle(0, 1, 1, $urandom);
    cycle(0, 0, 1, $urandom);
    cycle(0, 0, 0, 32'h0);

    // Beats offered outside a collection are ignored.
    repeat (3) cycle(1, 0, 1, $urandom);

    // Random phase.
    for (int n = 0; n < 300; n++) begin
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom);
    end
    data_req = 1'b0; reseed_req = 1'b0; entropy_ack = 1'b0;

    // Bypass instance: immediate ack, no entropy traffic, LFSR untouched, no periodic reseed.
    s_data_req = 1'b1;
    @(negedge clk);
    chk("skip_data_ack", 64'(s_data_ack), 64'd1);
    chk("skip_share0", s_data_o[0], share0(sk_lfsr));
    @(posedge clk);
    sk_lfsr = lfsr_step(sk_lfsr);
    #1;
    s_reseed_req = 1'b1; s_entropy_ack = 1'b1; s_entropy = $urandom;
    @(negedge clk);
    chk("skip_reseed_ack", 64'(s_reseed_ack), 64'd1);
    chk("skip_entropy_req", 64'(s_entropy_req), 64'd0);
    chk("skip_busy", 64'(s_reseed_busy), 64'd0);
    chk("skip_data_blocked", 64'(s_data_ack), 64'd0);
    @(posedge clk);
    #1;
    s_reseed_req = 1'b0; s_entropy_ack = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("skip_run_ack", 64'(s_data_ack), 64'd1);
      chk("skip_run_entropy_req", 64'(s_entropy_req), 64'd0);
      chk("skip_run_share0", s_data_o[0], share0(sk_lfsr));
      chk("skip_run_share1", s_data_o[1], share1(sk_lfsr));
      @(posedge clk);
      sk_lfsr = lfsr_step(sk_lfsr);
      #1;
    end
    s_data_req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
